// File: rtl/snake_state_keeper_if.sv
// ---------------------------------------------------------------------------
// snake_state_keeper_if
// Bundles the game-side signals exchanged between the snake state keeper and
// its environment (moving_snake, food generator, game timer).
//
// Signals:
//   game_tick    slow game clock, synchronous to clk
//   start        level start / restart request
//   next_pos_num candidate body, 16 segments x 10 bits, segment 0 = head
//   should_stop  wall or illegal-move flag
//   food_pos     current food cell
//   prev_pos_num registered body fed back to moving_snake
//   len          registered snake length
//   state        00 IDLE, 01 RUN, 10 OVER
//   eaten        one-clk pulse on a food hit
//   score        food count
//
// master: environment side (drives requests, observes state)
// slave : state keeper side
// ---------------------------------------------------------------------------
interface snake_state_keeper_if;
  logic         game_tick;
  logic         start;
  logic [159:0] next_pos_num;
  logic         should_stop;
  logic [9:0]   food_pos;
  logic [159:0] prev_pos_num;
  logic [3:0]   len;
  logic [1:0]   state;
  logic         eaten;
  logic [7:0]   score;

  modport master (
    output game_tick, start, next_pos_num, should_stop, food_pos,
    input  prev_pos_num, len, state, eaten, score
  );

  modport slave (
    input  game_tick, start, next_pos_num, should_stop, food_pos,
    output prev_pos_num, len, state, eaten, score
  );
endinterface

// File: rtl/snake_state_keeper.sv
// ---------------------------------------------------------------------------
// snake_state_keeper
// Holds the snake body, length, score and game state. On each rising edge of
// game_tick the candidate body from moving_snake is either committed (with
// growth on a food hit) or the game ends.
//
// Ports:
//   clk    system clock, all flops on the rising edge
//   rst_n  synchronous active-low reset
//   bus    snake_state_keeper_if.slave (see interface file for signal list)
//
// Optional feature: define SNAKE_SELF_COLLISION_EN to end the game when the
// new head lands on one of the live body segments. Without the macro only
// should_stop ends the game and no comparator logic exists.
// ---------------------------------------------------------------------------
module snake_state_keeper #(
  parameter logic [159:0] INIT_POS = {{14{10'h3FF}}, 10'd1, 10'd2},
  parameter logic [3:0]   INIT_LEN = 4'd2,
  parameter logic [3:0]   MAX_LEN  = 4'd15
) (
  input logic clk,
  input logic rst_n,
  snake_state_keeper_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] OVER = 2'b10;

  logic         gt_q;
  logic         tick_q,  tick_d;
  logic [1:0]   state_q, state_d;
  logic [159:0] body_q,  body_d;
  logic [3:0]   len_q,   len_d;
  logic [7:0]   score_q, score_d;
  logic         eaten_q, eaten_d;

  logic         self_hit;
  logic         food_hit;
  logic [3:0]   tail_idx;
  logic [7:0]   tail_base;
  logic [7:0]   grow_base;
  logic [9:0]   old_tail;

`ifdef SNAKE_SELF_COLLISION_EN
  // New head against every live segment 1..len-1 of the candidate body.
  always_comb begin
    self_hit = 1'b0;
    for (int k = 1; k < 16; k++) begin
      if ((4'(k) < len_q) && (bus.next_pos_num[k*10 +: 10] == bus.next_pos_num[9:0]))
        self_hit = 1'b1;
    end
  end
`else
  assign self_hit = 1'b0;
`endif

  assign food_hit  = (bus.next_pos_num[9:0] == bus.food_pos);
  assign tail_idx  = len_q - 4'd1;
  assign tail_base = 8'(tail_idx) * 8'd10;
  assign grow_base = 8'(len_q) * 8'd10;
  assign old_tail  = body_q[tail_base +: 10];

  // The tick is registered once more so the body commit lands two clocks
  // after the game_tick rise, giving moving_snake a settled candidate.
  always_comb begin
    tick_d  = bus.game_tick & ~gt_q;
    state_d = state_q;
    body_d  = body_q;
    len_d   = len_q;
    score_d = score_q;
    eaten_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start)
          state_d = RUN;
      end
      RUN: begin
        if (tick_q) begin
          if (bus.should_stop || self_hit) begin
            state_d = OVER;
          end else begin
            body_d = bus.next_pos_num;
            if (food_hit) begin
              eaten_d = 1'b1;
              if (score_q != 8'hFF)
                score_d = score_q + 8'd1;
              // Growth re-appends the old tail behind the shifted body.
              if (len_q < MAX_LEN) begin
                body_d[grow_base +: 10] = old_tail;
                len_d = len_q + 4'd1;
              end
            end
          end
        end
      end
      OVER: begin
        if (bus.start) begin
          state_d = RUN;
          body_d  = INIT_POS;
          len_d   = INIT_LEN;
          score_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // History flop resets high so a game_tick already high at reset release
  // does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_q    <= 1'b1;
      tick_q  <= 1'b0;
      state_q <= IDLE;
      body_q  <= INIT_POS;
      len_q   <= INIT_LEN;
      score_q <= 8'd0;
      eaten_q <= 1'b0;
    end else begin
      gt_q    <= bus.game_tick;
      tick_q  <= tick_d;
      state_q <= state_d;
      body_q  <= body_d;
      len_q   <= len_d;
      score_q <= score_d;
      eaten_q <= eaten_d;
    end
  end

  assign bus.prev_pos_num = body_q;
  assign bus.len          = len_q;
  assign bus.state        = state_q;
  assign bus.eaten        = eaten_q;
  assign bus.score        = score_q;

endmodule

// File: tb/tb_snake_state_keeper.sv
// ---------------------------------------------------------------------------
// tb_snake_state_keeper
// Directed and randomized checking of snake_state_keeper against a segment
// array reference model of the game rules.
// ---------------------------------------------------------------------------
module tb_snake_state_keeper;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  logic clk;
  logic rst_n;

  snake_state_keeper_if bus ();

  snake_state_keeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int testsRun;
  int failCount;

  // Reference model: body as an array of cells, plain integer length/score.
  logic [9:0] mBody [16];
  int         mLen;
  int         mScore;
  logic [1:0] mState;
  logic       mEaten;
  logic [9:0] tbNext [16];

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [159:0] packBody(input logic [9:0] b [16]);
    logic [159:0] r;
    for (int k = 0; k < 16; k++) r[k*10 +: 10] = b[k];
    return r;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mBody[0] = 10'd2;
    mBody[1] = 10'd1;
    for (int k = 2; k < 16; k++) mBody[k] = 10'h3FF;
    mLen   = 2;
    mScore = 0;
    mState = ST_IDLE;
    mEaten = 1'b0;
  endtask

  task automatic modelStart();
    if (mState == ST_IDLE) begin
      mState = ST_RUN;
    end else if (mState == ST_OVER) begin
      modelReset();
      mState = ST_RUN;
    end
  endtask

  // Game rules for one tick, applied to the model.
  task automatic modelTick(input logic stop, input logic [9:0] food);
    logic       coll;
    logic [9:0] oldTail;
    coll = 1'b0;
    if (mState != ST_RUN) return;
`ifdef SNAKE_SELF_COLLISION_EN
    for (int k = 1; k < mLen; k++)
      if (tbNext[k] == tbNext[0]) coll = 1'b1;
`endif
    if (stop || coll) begin
      mState = ST_OVER;
      return;
    end
    oldTail = mBody[mLen-1];
    for (int k = 0; k < 16; k++) mBody[k] = tbNext[k];
    if (tbNext[0] == food) begin
      mEaten = 1'b1;
      if (mScore < 255) mScore = mScore + 1;
      if (mLen < 15) begin
        mBody[mLen] = oldTail;
        mLen = mLen + 1;
      end
    end
  endtask

  // Candidate body as moving_snake would produce it: new head, rest shifted.
  task automatic makeNext(input logic [9:0] head);
    tbNext[0] = head;
    for (int k = 1; k < 16; k++) tbNext[k] = mBody[k-1];
  endtask

  task automatic checkOutput(input string tag);
    logic [159:0] expBody;
    expBody = packBody(mBody);
    testsRun++;
    assert (bus.state === mState) else begin
      failCount++;
      $error("[TB] FAIL %s state got %0d exp %0d", tag, bus.state, mState);
    end
    testsRun++;
    assert (bus.prev_pos_num === expBody) else begin
      failCount++;
      $error("[TB] FAIL %s body got %h exp %h", tag, bus.prev_pos_num, expBody);
    end
    testsRun++;
    assert (bus.len === 4'(mLen)) else begin
      failCount++;
      $error("[TB] FAIL %s len got %0d exp %0d", tag, bus.len, mLen);
    end
    testsRun++;
    assert (bus.score === 8'(mScore)) else begin
      failCount++;
      $error("[TB] FAIL %s score got %0d exp %0d", tag, bus.score, mScore);
    end
    testsRun++;
    assert (bus.eaten === mEaten) else begin
      failCount++;
      $error("[TB] FAIL %s eaten got %0d exp %0d", tag, bus.eaten, mEaten);
    end
  endtask

  // One full game tick: rise, latency check, commit check, pulse end check.
  task automatic applyStimulus(input logic stop, input logic [9:0] food,
                               input logic holdStart, input string tag);
    bus.next_pos_num = packBody(tbNext);
    bus.should_stop  = stop;
    bus.food_pos     = food;
    bus.start        = holdStart;
    bus.game_tick    = 1'b1;
    stepClk();
    checkOutput({tag, "_lat"});
    stepClk();
    bus.start = 1'b0;
    modelTick(stop, food);
    checkOutput(tag);
    bus.game_tick = 1'b0;
    stepClk();
    mEaten = 1'b0;
    checkOutput({tag, "_post"});
    stepClk();
  endtask

  task automatic pressStart();
    bus.start = 1'b1;
    stepClk();
    bus.start = 1'b0;
    modelStart();
  endtask

  initial begin
    logic [9:0] head;
    logic [9:0] food;
    logic       stop;
    logic       hold;
    testsRun  = 0;
    failCount = 0;

    // Reset with game_tick and start already high.
    rst_n = 1'b0;
    bus.game_tick    = 1'b1;
    bus.start        = 1'b1;
    bus.should_stop  = 1'b0;
    bus.food_pos     = 10'd500;
    bus.next_pos_num = {16{10'h155}};
    repeat (3) stepClk();
    modelReset();
    checkOutput("reset");

    // Release: start is seen, but the high game_tick must not be a tick.
    rst_n = 1'b1;
    stepClk();
    modelStart();
    bus.start = 1'b0;
    repeat (3) stepClk();
    checkOutput("release_no_tick");
    bus.game_tick = 1'b0;
    repeat (2) stepClk();

    // Plain move, no food.
    makeNext(10'd3);
    applyStimulus(1'b0, 10'd500, 1'b0, "move");

    // Food hit with growth.
    makeNext(10'd4);
    applyStimulus(1'b0, 10'd4, 1'b0, "eat_grow");

    // Grow to the length limit.
    head = 10'd5;
    while (mLen < 15) begin
      makeNext(head);
      applyStimulus(1'b0, head, 1'b0, "grow_loop");
      head = head + 10'd1;
    end
    makeNext(head);
    applyStimulus(1'b0, head, 1'b0, "eat_at_max");

    // Stop ends the game, later ticks are ignored.
    makeNext(10'd20);
    applyStimulus(1'b1, 10'd500, 1'b0, "stop");
    makeNext(10'd21);
    applyStimulus(1'b0, 10'd21, 1'b0, "over_tick");

    // Restart coinciding with a registered tick: tick dropped.
    makeNext(10'd30);
    bus.next_pos_num = packBody(tbNext);
    bus.food_pos     = 10'd30;
    bus.game_tick    = 1'b1;
    stepClk();
    pressStart();
    bus.game_tick = 1'b0;
    repeat (2) stepClk();
    checkOutput("restart_with_tick");

    // Length 5 then head onto segment 3.
    for (int i = 3; i < 6; i++) begin
      makeNext(10'(i));
      applyStimulus(1'b0, 10'(i), 1'b0, "grow5");
    end
    makeNext(10'd3);
    applyStimulus(1'b0, 10'd500, 1'b0, "self_hit");

    // Randomized play, occasionally holding start during RUN ticks.
    for (int n = 0; n < 150; n++) begin
      if (mState != ST_RUN) begin
        pressStart();
        stepClk();
        checkOutput("rand_start");
      end
      head = 10'($urandom_range(0, 20));
      food = ($urandom_range(0, 2) == 0) ? head : 10'($urandom_range(0, 20));
      stop = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 7) == 0);
      makeNext(head);
      applyStimulus(stop, food, hold, "rand");
    end

    // Reset in the middle of a tick.
    if (mState != ST_RUN) begin
      pressStart();
      stepClk();
    end
    makeNext(10'd9);
    bus.next_pos_num = packBody(tbNext);
    bus.should_stop  = 1'b0;
    bus.game_tick    = 1'b1;
    stepClk();
    rst_n = 1'b0;
    stepClk();
    modelReset();
    checkOutput("mid_tick_reset");
    rst_n = 1'b1;
    repeat (2) stepClk();
    checkOutput("mid_tick_release");
    bus.game_tick = 1'b0;
    stepClk();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
